// File: rtl/periph_timer_if.sv
// periph_timer_if: memory-window register port between a bus master and periph_timer
//   data_periph_out   master->slave  byte-merged write data
//   data_periph_write master->slave  per-word write strobes
//   data_periph_in    slave->master  flat register readback, word i at [DataWidth*i +: DataWidth]
//   timer_irq         slave->master  registered machine-timer interrupt
interface periph_timer_if #(
  parameter int DataWidth = 32,
  parameter int SizeWords = 8
);
  logic [DataWidth-1:0]           data_periph_out;
  logic [SizeWords-1:0]           data_periph_write;
  logic [SizeWords*DataWidth-1:0] data_periph_in;
  logic                           timer_irq;
  modport master (output data_periph_out, data_periph_write, input data_periph_in, timer_irq);
  modport slave (input data_periph_out, data_periph_write, output data_periph_in, timer_irq);
endinterface

// File: rtl/periph_timer.sv
// periph_timer: memory-mapped 64-bit machine timer with prescaler and compare interrupt
//   clk, rst  system clock and synchronous active-high reset
//   bus       periph_timer_if.slave register window (words: MTIME_LO/HI, MTIMECMP_LO/HI, CTRL, STATUS, reserved)
module periph_timer #(
  parameter int DataWidth     = 32,
  parameter int SizeWords     = 8,
  parameter int PrescaleWidth = 16
) (
  input logic           clk,
  input logic           rst,
  periph_timer_if.slave bus
);
  logic [63:0]                    r_mtime, r_mtimecmp;
  logic [PrescaleWidth-1:0]       r_div, r_cnt;
  logic                           r_en, r_irq;
  logic [31:0]                    w_wd;
  logic [SizeWords-1:0]           w_we;
  logic [63:0]                    w_inc;
  logic                           w_tick, w_mwr, w_unused;
  logic [SizeWords*DataWidth-1:0] w_rd;
  assign w_wd   = bus.data_periph_out[31:0];
  assign w_we   = bus.data_periph_write;
  assign w_tick = r_en && r_cnt == r_div;
  assign w_inc  = r_mtime + 64'd1;
  // Any MTIME write suppresses the tick for both halves, so no carry leaks into the unwritten half.
  assign w_mwr  = w_we[0] | w_we[1];
  // STATUS and reserved strobes are deliberately ignored.
  assign w_unused = ^w_we[SizeWords-1:5];
  always_ff @(posedge clk)
    if (rst) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_en       <= 1'b0;
      r_div      <= '0;
      r_cnt      <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_mtime[31:0]  <= w_we[0] ? w_wd : (w_mwr || !w_tick) ? r_mtime[31:0] : w_inc[31:0];
      r_mtime[63:32] <= w_we[1] ? w_wd : (w_mwr || !w_tick) ? r_mtime[63:32] : w_inc[63:32];
      if (w_we[2]) r_mtimecmp[31:0] <= w_wd;
      if (w_we[3]) r_mtimecmp[63:32] <= w_wd;
      if (w_we[4]) begin
        r_en  <= w_wd[0];
        r_div <= w_wd[16 +: PrescaleWidth];
      end
      r_cnt <= (w_we[4] || w_tick) ? '0 : r_en ? r_cnt + 1'b1 : r_cnt;
      r_irq <= r_mtime >= r_mtimecmp;
    end
  always_comb begin
    w_rd                           = '0;
    w_rd[0 +: 32]                  = r_mtime[31:0];
    w_rd[DataWidth +: 32]          = r_mtime[63:32];
    w_rd[2*DataWidth +: 32]        = r_mtimecmp[31:0];
    w_rd[3*DataWidth +: 32]        = r_mtimecmp[63:32];
    w_rd[4*DataWidth +: DataWidth] = DataWidth'({r_div, 15'd0, r_en});
    w_rd[5*DataWidth]              = r_irq;
  end
  assign bus.data_periph_in = w_rd;
  assign bus.timer_irq      = r_irq;
endmodule

// File: doc/periph_timer.md
PERIPH_TIMER -- requirements
Module: periph_timer

Interface
REQ-001 The block SHALL have parameter DataWidth, default 32, word width of the peripheral register port.
REQ-002 The block SHALL have parameter SizeWords, default 8, number of word registers in the peripheral window.
REQ-003 The block SHALL have parameter PrescaleWidth, default 16, width of the prescale divisor and counter (at most DataWidth-16).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  system clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 data_periph_out  input  DataWidth  byte-merged write data from the memory-window interface.
REQ-008 data_periph_write  input  SizeWords  per-word write strobes from the memory-window interface.
REQ-009 data_periph_in  output  SizeWords*DataWidth  register readback; word i at bits [DataWidth*i +: DataWidth].
REQ-010 timer_irq  output  1  registered machine-timer interrupt request.

Function
REQ-011 Register map, by word index: 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI, 4 CTRL, 5 STATUS, 6-7 reserved.
REQ-012 MTIME and MTIMECMP SHALL each be 64-bit; LO holds bits [31:0], HI holds bits [63:32].
REQ-013 CTRL bit0 = enable; CTRL bits [16 +: PrescaleWidth] = divisor; all other CTRL bits read 0, writes ignored.
REQ-014 STATUS bit0 SHALL read the current timer_irq value; other bits read 0; STATUS is read-only, writes ignored.
REQ-015 Reserved words SHALL read 0 and ignore writes.
REQ-016 data_periph_in SHALL be combinational from register state, with no added latency.
REQ-017 A write strobe SHALL load data_periph_out into the addressed register at the next edge.
REQ-018 Each strobe acts independently; simultaneous strobes each load data_periph_out.
REQ-019 While enable=1, the prescale counter SHALL increment each cycle.
REQ-020 When the counter equals the divisor, a tick occurs: the counter returns to 0 and MTIME increments by 1 with full 64-bit carry from LO to HI.
REQ-021 Divisor 0 SHALL tick every cycle; divisor N SHALL tick every N+1 cycles.
REQ-022 While enable=0, the prescale counter and MTIME SHALL hold.
REQ-023 Any write to CTRL SHALL clear the prescale counter to 0 in the same edge.
REQ-024 A write to MTIME_LO or MTIME_HI SHALL take priority over a coincident tick: the written half takes the written value, the other half is unchanged, and no carry occurs that cycle.
REQ-025 MTIME SHALL wrap from 0xFFFF_FFFF_FFFF_FFFF to 0 on a tick.
REQ-026 timer_irq SHALL be registered as (MTIME >= MTIMECMP), unsigned, evaluated on the current register values, so the interrupt asserts one cycle after the condition becomes true.
REQ-027 timer_irq SHALL be level, not sticky; it deasserts one cycle after a write makes MTIMECMP > MTIME.

Reset
REQ-028 On rst=1 at an edge: MTIME=0, MTIMECMP=0xFFFF_FFFF_FFFF_FFFF, CTRL=0, prescale counter=0, timer_irq=0.
REQ-029 Reset SHALL dominate coincident write strobes and ticks.
REQ-030 Reset mid-count SHALL discard any partial prescale count.

Verification
REQ-031 Reset, then read all eight words -> 0, 0, 0xFFFFFFFF, 0xFFFFFFFF, 0, 0, 0, 0; timer_irq=0.
REQ-032 CTRL=0x0003_0001 (divisor 3, enable) -> MTIME_LO increments every 4 cycles; after 40 cycles MTIME_LO=10.
REQ-033 MTIME_LO=0xFFFFFFFF, MTIME_HI=0, divisor 0, enable -> after one tick MTIME_HI=1 and MTIME_LO=0. With MTIME=all-ones, the next tick -> MTIME=0.
REQ-034 MTIMECMP=5, MTIME=0, divisor 0, enable -> timer_irq rises on the cycle after MTIME_LO reaches 5. Then write MTIMECMP_LO=100 -> timer_irq falls one cycle later; STATUS tracks timer_irq.
REQ-035 Write MTIME_LO=0x1234 on a tick cycle -> MTIME_LO=0x1234 with no increment. A write to reserved word 6 and to STATUS -> both remain 0.
REQ-036 Assert rst for one cycle mid-count with enable=1 -> all REQ-028 values on the next cycle, and counting stops (enable=0).
